// File: rtl/power_issue.sv
// power_issue: operand FIFO + issue register + result register around an external combinational fp32 pow unit.
// Latency: a pair accepted at edge k drives pow_input* after edge k+1; its result is valid after edge k+2.
// Backpressure: the result register holds while out_valid && !out_ready; in_ready drops when the FIFO is full.
// Optional: define POWER_ISSUE_STATS_EN to build the saturating special_count bypass counter (tied to 0 otherwise).

module power_issue #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inputA,
    input  logic [31:0]        inputB,
    output logic [31:0]        pow_inputA,
    output logic [31:0]        pow_inputB,
    input  logic [31:0]        pow_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out,
    output logic               out_special,
    output logic [COUNT_W-1:0] special_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [31:0]   fifo_a_q [DEPTH];
    logic [31:0]   fifo_b_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // ------------------------------------------------------------------
    // Issue stage (S1) and output stage (S2)
    // ------------------------------------------------------------------
    logic          s1_vld_q, s1_vld_d;
    logic [31:0]   s1_a_q, s1_a_d;      // base with sign already cleared
    logic [31:0]   s1_b_q, s1_b_d;
    logic          s1_byp_q, s1_byp_d;  // entry resolved by classification
    logic [31:0]   s1_val_q, s1_val_d;  // bypass result when s1_byp_q
    logic          s1_neg_q, s1_neg_d;  // negative base raised to odd integer
    logic          s1_adv;

    logic          s2_vld_q, s2_vld_d;
    logic [31:0]   out_q, out_d;
    logic          spec_q, spec_d;

    // ------------------------------------------------------------------
    // Classification of the FIFO head
    // ------------------------------------------------------------------
    logic [31:0]   hd_a;
    logic [31:0]   hd_b;
    logic          a_sgn, b_sgn;
    logic [7:0]    a_exp, b_exp;
    logic [22:0]   a_frc, b_frc;
    logic          a_zero, a_inf, a_nan, a_one;
    logic          b_zero, b_inf, b_nan;
    logic          b_int, b_odd;
    logic          cls_byp;
    logic [31:0]   cls_val;
    logic          cls_neg;

    // Count is registered so in_ready never depends combinationally on out_ready.
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign in_ready   = !fifo_full;

    assign s1_adv = s1_vld_q && (!s2_vld_q || out_ready);
    assign push   = in_valid && !fifo_full;
    assign pop    = !fifo_empty && (!s1_vld_q || s1_adv);

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // FIFO state registers; storage itself needs no reset because count gates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= inputA;
            fifo_b_q[wr_ptr_q] <= inputB;
        end
    end

    assign hd_a = fifo_a_q[rd_ptr_q];
    assign hd_b = fifo_b_q[rd_ptr_q];

    // Field decode; denormals count as signed zero.
    always_comb begin
        a_sgn  = hd_a[31];
        a_exp  = hd_a[30:23];
        a_frc  = hd_a[22:0];
        b_sgn  = hd_b[31];
        b_exp  = hd_b[30:23];
        b_frc  = hd_b[22:0];

        a_zero = (a_exp == 8'h00);
        a_inf  = (a_exp == 8'hFF) && (a_frc == '0);
        a_nan  = (a_exp == 8'hFF) && (a_frc != '0);
        a_one  = (hd_a == FP_ONE);
        b_zero = (b_exp == 8'h00);
        b_inf  = (b_exp == 8'hFF) && (b_frc == '0);
        b_nan  = (b_exp == 8'hFF) && (b_frc != '0);
    end

    // Integer / odd test on the exponent operand. With e = exp-127, fraction
    // bits below weight 2^0 are [22-e:0]; the units bit is bit (23-e) of {1,frac}.
    always_comb begin
        b_int = 1'b0;
        b_odd = 1'b0;
        if (b_zero) begin
            b_int = 1'b1;
        end else if (b_exp >= 8'd150) begin
            b_int = 1'b1;
        end else if (b_exp >= 8'd127) begin
            b_int = ((b_frc & (23'h7F_FFFF >> (b_exp - 8'd127))) == 23'd0);
        end

        if ((b_exp == 8'd127) && (b_frc == '0)) begin
            b_odd = 1'b1;
        end else if ((b_exp >= 8'd128) && (b_exp <= 8'd150)) begin
            b_odd = |(({1'b1, b_frc} >> (8'd150 - b_exp)) & 24'd1);
        end
    end

    // Special-value bypass, first matching rule wins.
    always_comb begin
        cls_byp = 1'b1;
        cls_val = FP_ZERO;
        if (b_zero) begin
            cls_val = FP_ONE;
        end else if (a_one) begin
            cls_val = FP_ONE;
        end else if (a_nan || b_nan) begin
            cls_val = FP_QNAN;
        end else if (a_zero && !b_sgn) begin
            cls_val = FP_ZERO;
        end else if (a_zero && b_sgn) begin
            cls_val = FP_PINF;
        end else if (a_inf || b_inf) begin
            cls_val = FP_QNAN;
        end else if (a_sgn && !b_int) begin
            cls_val = FP_QNAN;
        end else begin
            cls_byp = 1'b0;
        end
        cls_neg = a_sgn && b_odd;
    end

    // Issue register: load from the FIFO head, or empty out when it moves on.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_byp_d = s1_byp_q;
        s1_val_d = s1_val_q;
        s1_neg_d = s1_neg_q;
        if (pop) begin
            s1_vld_d = 1'b1;
            s1_a_d   = {1'b0, hd_a[30:0]};
            s1_b_d   = hd_b;
            s1_byp_d = cls_byp;
            s1_val_d = cls_val;
            s1_neg_d = cls_neg;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end
    end

    // Issue register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_byp_q <= 1'b0;
            s1_val_q <= '0;
            s1_neg_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_byp_q <= s1_byp_d;
            s1_val_q <= s1_val_d;
            s1_neg_q <= s1_neg_d;
        end
    end

    // The pow unit sees S1 even for bypassed entries; its result is then discarded.
    assign pow_inputA = s1_a_q;
    assign pow_inputB = s1_b_q;

    // Output register: capture the pow result (sign forced) or the bypass value.
    always_comb begin
        s2_vld_d = s2_vld_q;
        out_d    = out_q;
        spec_d   = spec_q;
        if (s1_adv) begin
            s2_vld_d = 1'b1;
            spec_d   = s1_byp_q;
            out_d    = s1_byp_q ? s1_val_q : {s1_neg_q, 31'(pow_out & 32'h7FFF_FFFF)};
        end else if (out_ready) begin
            s2_vld_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            out_q    <= '0;
            spec_q   <= 1'b0;
        end else begin
            s2_vld_q <= s2_vld_d;
            out_q    <= out_d;
            spec_q   <= spec_d;
        end
    end

    assign out_valid   = s2_vld_q;
    assign out         = out_q;
    assign out_special = spec_q;

`ifdef POWER_ISSUE_STATS_EN
    logic [COUNT_W-1:0] scnt_q, scnt_d;

    // Count bypassed results as they are consumed, saturating at all-ones.
    always_comb begin
        scnt_d = scnt_q;
        if (s2_vld_q && out_ready && spec_q && (scnt_q != '1)) begin
            scnt_d = scnt_q + COUNT_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign special_count = scnt_q;
`else
    assign special_count = '0;
`endif

endmodule

// File: tb/tb_power_issue.sv
module tb_power_issue;

    localparam int DEPTH   = 4;
    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [31:0]        inputA = '0;
    logic [31:0]        inputB = '0;
    logic [31:0]        pow_out;
    logic               in_ready;
    logic               out_valid;
    logic               out_special;
    logic [31:0]        pow_inputA;
    logic [31:0]        pow_inputB;
    logic [31:0]        out;
    logic [COUNT_W-1:0] special_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_model = 0;
    int out_seen = 0;
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;
    logic [31:0] mon_v;
    logic        mon_s;

    always #5 clk = ~clk;

    power_issue #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inputA(inputA), .inputB(inputB),
        .pow_inputA(pow_inputA), .pow_inputB(pow_inputB), .pow_out(pow_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_special(out_special),
        .special_count(special_count)
    );

    // fp32 -> real (denormals, inf and NaN collapse to 0; callers handle those by encoding)
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] bits;
        if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) return 0.0;
        bits = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        return $bitstoreal(bits);
    endfunction

    // real -> fp32, truncating, with overflow to inf and underflow to zero
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] bits;
        int e;
        bits = $realtobits(r);
        if (bits[62:52] == 11'h7FF) return (bits[51:0] != 0) ? 32'h7FC0_0000 : {bits[63], 8'hFF, 23'd0};
        if (bits[62:52] == 11'h000) return {bits[63], 31'd0};
        e = int'(bits[62:52]) - 1023 + 127;
        if (e >= 255) return {bits[63], 8'hFF, 23'd0};
        if (e <= 0) return {bits[63], 31'd0};
        return {bits[63], e[7:0], bits[51:29]};
    endfunction

    function automatic logic [31:0] stub_pow(input logic [31:0] a, input logic [31:0] b);
        return r2f($pow(f2r(a), f2r(b)));
    endfunction

    // Power unit stand-in: exact pow of the issued operands.
    always_comb pow_out = stub_pow(pow_inputA, pow_inputB);

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 0);
    endfunction

    // Reference result of pow(A,B) for this block, from the special-case rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] v, output logic s);
        real br;
        bit  b_int, b_odd;
        br = f2r(b);
        s  = 1'b1;
        v  = 32'h0;
        if (b[30:23] == 8'h00)                 v = 32'h3F80_0000;
        else if (a == 32'h3F80_0000)           v = 32'h3F80_0000;
        else if (is_nan(a) || is_nan(b))      v = 32'h7FC0_0000;
        else if (a[30:23] == 8'h00 && !b[31])  v = 32'h0000_0000;
        else if (a[30:23] == 8'h00)            v = 32'h7F80_0000;
        else if (is_inf(a) || is_inf(b))      v = 32'h7FC0_0000;
        else begin
            b_int = ($floor(br) == br);
            b_odd = 1'b0;
            if (b_int && (br < 16777216.0) && (br > -16777216.0))
                b_odd = ((longint'(br) % 2) != 0);
            if (a[31] && !b_int) v = 32'h7FC0_0000;
            else begin
                s = 1'b0;
                v = stub_pow({1'b0, a[30:0]}, b);
                v[31] = a[31] && b_odd;
            end
        end
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: record accepted pairs, match results in order, track the counter.
    always @(negedge clk) begin
        check_val("special_count", 32'(special_count), 32'(cnt_model));
        if (rst) begin
            exp_q.delete();
            cnt_model = 0;
        end else begin
            if (out_valid && out_ready) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("out", out, mon_e[31:0]);
                    check_val("out_special", 32'(out_special), 32'(mon_e[32]));
`ifdef POWER_ISSUE_STATS_EN
                    if (mon_e[32] && cnt_model < (1 << COUNT_W) - 1) cnt_model++;
`endif
                end
            end
            if (in_valid && in_ready) begin
                model(inputA, inputB, mon_v, mon_s);
                exp_q.push_back({mon_s, mon_v});
            end
        end
    end

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eout, input logic esp);
        @(posedge clk) #1;
        in_valid = 1'b1; inputA = a; inputB = b;
        @(posedge clk) #1;
        in_valid = 1'b0;
        check_val("lat_k_vld", 32'(out_valid), 32'd0);
        @(posedge clk) #1;
        check_val("pow_inputA", pow_inputA, {1'b0, a[30:0]});
        check_val("pow_inputB", pow_inputB, b);
        check_val("lat_k1_vld", 32'(out_valid), 32'd0);
        @(posedge clk) #1;
        check_val("lat_k2_vld", 32'(out_valid), 32'd1);
        check_val("dir_out", out, eout);
        check_val("dir_special", 32'(out_special), 32'(esp));
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk) #1;
        in_valid = 1'b1; inputA = a; inputB = b;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check_val("push_timeout", 32'd1, 32'd0);
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk) #1;
            if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
        end
        check_val("drain_done", 32'(ok), 32'd1);
    endtask

    function automatic logic [31:0] rand_a();
        logic [31:0] pool [15] = '{32'h0, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
            32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'hFFC0_0001, 32'h0000_0005,
            32'h8040_0000, 32'h4000_0000, 32'hC000_0000, 32'hC040_0000, 32'h3F00_0000,
            32'hBFC0_0000};
        int k;
        k = $urandom_range(0, 24);
        if (k < 15) return pool[k];
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_b();
        logic [31:0] pool [15] = '{32'h0, 32'h8000_0000, 32'h0000_0003, 32'h3F80_0000,
            32'hBF80_0000, 32'h4000_0000, 32'h4040_0000, 32'hC040_0000, 32'h3F00_0000,
            32'h4B00_0001, 32'h4B80_0000, 32'h4B7F_FFFF, 32'h7F80_0000, 32'h7FC0_0000,
            32'h4120_0000};
        int k;
        k = $urandom_range(0, 24);
        if (k < 15) return pool[k];
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 152)), 23'($urandom)};
    endfunction

    initial begin
        int acc;
        int seen0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out", out, 32'd0);
        check_val("rst_out_special", 32'(out_special), 32'd0);
        check_val("rst_special_count", 32'(special_count), 32'd0);

        // latency, sign handling and bypass values
        out_ready = 1'b1;
        directed(32'h4000_0000, 32'h4040_0000, 32'h4100_0000, 1'b0);
        directed(32'hC000_0000, 32'h4040_0000, 32'hC100_0000, 1'b0);
        directed(32'hC000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
        directed(32'hC000_0000, 32'h4020_0000, 32'h7FC0_0000, 1'b1);
        directed(32'h7FC0_0000, 32'h8000_0000, 32'h3F80_0000, 1'b1);
        directed(32'h0000_0000, 32'hBF80_0000, 32'h7F80_0000, 1'b1);
        directed(32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
        directed(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1);
        directed(32'h3F80_0000, 32'h7FC0_0000, 32'h3F80_0000, 1'b1);
        drain();

        // backpressure: capacity is DEPTH+2
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk) #1;
            in_valid = 1'b1;
            inputA = 32'h4000_0000 + (32'(acc) << 16);
            inputB = 32'h3F80_0000;
            @(negedge clk);
            if (in_ready) acc++;
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        check_val("bp_accepted", 32'(acc), 32'(DEPTH + 2));
        check_val("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(negedge clk);
            check_val("bp_stream_vld", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        check_val("bp_stream_end", 32'(out_valid), 32'd0);
        check_val("bp_all_out", 32'(exp_q.size()), 32'd0);

        // randomized traffic with random backpressure
        for (int c = 0; c < 800; c++) begin
            @(posedge clk) #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            inputA    = rand_a();
            inputB    = rand_b();
        end
        drain();

        // reset with entries in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            in_valid = 1'b1; inputA = 32'h4040_0000; inputB = 32'h4000_0000;
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        check_val("flush_out_valid", 32'(out_valid), 32'd0);
        check_val("flush_in_ready", 32'(in_ready), 32'd1);
        check_val("flush_count", 32'(special_count), 32'd0);

        // post-reset traffic: three specials and two normal results
        out_ready = 1'b1;
        seen0 = out_seen;
        push(32'h7FC0_0000, 32'h8000_0000);
        push(32'h4000_0000, 32'h4040_0000);
        push(32'h0000_0000, 32'hBF80_0000);
        push(32'hC000_0000, 32'h4000_0000);
        push(32'h7F80_0000, 32'h3F80_0000);
        drain();
        check_val("post_rst_outputs", 32'(out_seen - seen0), 32'd5);
`ifdef POWER_ISSUE_STATS_EN
        check_val("stats_count", 32'(special_count), 32'd3);
`else
        check_val("stats_count", 32'(special_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
